// File: rtl/acq_stream_ctrl_pkg.sv
// Shared types and constants for the acquisition frame scheduler.
package acq_pkg;

    // Scheduler states: waiting for start, waiting for FIFO room for the
    // header, and streaming sample pairs.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2
    } acq_state_e;

    // Source-pair selection, written into the header so the host knows
    // what each channel carries.
    typedef enum logic [1:0] {
        MODE_ADC_ADC    = 2'd0,
        MODE_ADC1_CONVA = 2'd1,
        MODE_ADC2_CONVB = 2'd2,
        MODE_CONV_CONV  = 2'd3
    } acq_mode_e;

    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam int         HDR_W   = 16;

    // Header word: tag, mode of the frame that follows, low frame count bits.
    function automatic logic [HDR_W-1:0] make_header(input acq_mode_e  mode,
                                                     input logic [9:0] frame_lsb);
        return {HDR_TAG, mode, frame_lsb};
    endfunction

endpackage

// File: rtl/acq_stream_ctrl_if.sv
// Write side of the two Ethernet FIFOs as seen by the frame scheduler.
interface acq_stream_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] fifo_din_a;
    logic [DATA_W-1:0] fifo_din_b;
    logic              fifo_wr_a;
    logic              fifo_wr_b;
    logic              fifo_full_a;
    logic              fifo_full_b;

    // Scheduler side: drives data and enables, watches the full flags.
    modport master (
        output fifo_din_a,
        output fifo_din_b,
        output fifo_wr_a,
        output fifo_wr_b,
        input  fifo_full_a,
        input  fifo_full_b
    );

    // FIFO side: accepts writes, reports full.
    modport slave (
        input  fifo_din_a,
        input  fifo_din_b,
        input  fifo_wr_a,
        input  fifo_wr_b,
        output fifo_full_a,
        output fifo_full_b
    );
endinterface

// File: rtl/acq_stream_ctrl_src_mux.sv
// Combinational 4-way selection of the channel A/B sample pair.
module acq_src_mux
    import acq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  acq_mode_e         mode_i,
    input  logic [DATA_W-1:0] adc_a_i,
    input  logic [DATA_W-1:0] adc_b_i,
    input  logic [DATA_W-1:0] conv_a_i,
    input  logic [DATA_W-1:0] conv_b_i,
    output logic [DATA_W-1:0] pair_a_o,
    output logic [DATA_W-1:0] pair_b_o
);

    // Pick the pair for the active mode; ADC1 is always on A when it is used.
    always_comb begin
        pair_a_o = adc_a_i;
        pair_b_o = adc_b_i;
        case (mode_i)
            MODE_ADC_ADC: begin
                pair_a_o = adc_a_i;
                pair_b_o = adc_b_i;
            end
            MODE_ADC1_CONVA: begin
                pair_a_o = adc_a_i;
                pair_b_o = conv_a_i;
            end
            MODE_ADC2_CONVB: begin
                pair_a_o = adc_b_i;
                pair_b_o = conv_b_i;
            end
            MODE_CONV_CONV: begin
                pair_a_o = conv_a_i;
                pair_b_o = conv_b_i;
            end
            default: begin
                pair_a_o = adc_a_i;
                pair_b_o = adc_b_i;
            end
        endcase
    end

endmodule

// File: rtl/acq_stream_ctrl.sv
// Frame scheduler: header + FRAME_LEN sample pairs per frame into two
// word-aligned FIFOs, with frame and overflow counters.
module acq_stream_ctrl #(
    parameter int FRAME_LEN = 255,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_valid,
    input  logic [1:0]        cfg_mode,
    input  logic              smp_stb,
    input  logic [DATA_W-1:0] adc_a,
    input  logic [DATA_W-1:0] adc_b,
    input  logic [DATA_W-1:0] conv_a,
    input  logic [DATA_W-1:0] conv_b,
    acq_stream_ctrl_if.master fifo,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        ovf_cnt,
    output logic              busy
);
    import acq_pkg::*;

    localparam int               CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    acq_state_e        state_q, state_d;
    acq_mode_e         mode_pend_q, mode_pend_d;
    acq_mode_e         mode_act_q, mode_act_d;
    logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]        ovf_cnt_q, ovf_cnt_d;
    logic              busy_q, busy_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] din_a_q, din_a_d;
    logic [DATA_W-1:0] din_b_q, din_b_d;

    logic              any_full;
    logic [DATA_W-1:0] pair_a, pair_b;
    logic [DATA_W-1:0] hdr_word;

    // Both channels are gated by either full flag so they never drift apart.
    assign any_full = fifo.fifo_full_a | fifo.fifo_full_b;
    assign hdr_word = DATA_W'(make_header(mode_pend_q, frame_cnt_q[9:0]));

    acq_src_mux #(
        .DATA_W (DATA_W)
    ) u_src_mux (
        .mode_i   (mode_act_q),
        .adc_a_i  (adc_a),
        .adc_b_i  (adc_b),
        .conv_a_i (conv_a),
        .conv_b_i (conv_b),
        .pair_a_o (pair_a),
        .pair_b_o (pair_b)
    );

    // Next-state and registered-output decisions for header/sample writes.
    always_comb begin
        state_d     = state_q;
        mode_pend_d = cfg_valid ? acq_mode_e'(cfg_mode) : mode_pend_q;
        mode_act_d  = mode_act_q;
        smp_cnt_d   = smp_cnt_q;
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        wr_d        = 1'b0;
        din_a_d     = din_a_q;
        din_b_d     = din_b_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                // Strobes here are deliberately ignored: no frame is open yet.
                if (!any_full) begin
                    wr_d       = 1'b1;
                    din_a_d    = hdr_word;
                    din_b_d    = hdr_word;
                    mode_act_d = mode_pend_q;
                    smp_cnt_d  = '0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (smp_stb) begin
                    if (any_full) begin
                        if (ovf_cnt_q != 8'hFF) begin
                            ovf_cnt_d = ovf_cnt_q + 8'd1;
                        end
                    end else begin
                        wr_d      = 1'b1;
                        din_a_d   = pair_a;
                        din_b_d   = pair_b;
                        smp_cnt_d = smp_cnt_q + 1'b1;
                        // Frame only closes on a real write; start is checked
                        // here so a dropped start never truncates a frame.
                        if (smp_cnt_q == LAST_IDX) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            state_d     = start ? ARM : IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and output registers; reset abandons any open frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_pend_q <= MODE_ADC_ADC;
            mode_act_q  <= MODE_ADC_ADC;
            smp_cnt_q   <= '0;
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
            busy_q      <= 1'b0;
            wr_q        <= 1'b0;
            din_a_q     <= '0;
            din_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_pend_q <= mode_pend_d;
            mode_act_q  <= mode_act_d;
            smp_cnt_q   <= smp_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            busy_q      <= busy_d;
            wr_q        <= wr_d;
            din_a_q     <= din_a_d;
            din_b_q     <= din_b_d;
        end
    end

    assign fifo.fifo_wr_a  = wr_q;
    assign fifo.fifo_wr_b  = wr_q;
    assign fifo.fifo_din_a = din_a_q;
    assign fifo.fifo_din_b = din_b_q;
    assign frame_cnt       = frame_cnt_q;
    assign ovf_cnt         = ovf_cnt_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_acq_stream_ctrl.sv
// Bench for acq_stream_ctrl: frame-level reference model, per-cycle compare,
// and literal checks on captured header/sample words.
module tb_acq_stream_ctrl;

    localparam int FRAME_LEN = 255;
    localparam int DATA_W    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic        smp_stb = 1'b0;
    logic [15:0] adc_a = '0, adc_b = '0, conv_a = '0, conv_b = '0;
    logic        full_a = 1'b0, full_b = 1'b0;
    logic [15:0] frame_cnt;
    logic [7:0]  ovf_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    acq_stream_ctrl_if #(.DATA_W(DATA_W)) fifo_if ();
    assign fifo_if.fifo_full_a = full_a;
    assign fifo_if.fifo_full_b = full_b;

    acq_stream_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .DATA_W    (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_valid (cfg_valid),
        .cfg_mode  (cfg_mode),
        .smp_stb   (smp_stb),
        .adc_a     (adc_a),
        .adc_b     (adc_b),
        .conv_a    (conv_a),
        .conv_b    (conv_b),
        .fifo      (fifo_if),
        .frame_cnt (frame_cnt),
        .ovf_cnt   (ovf_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = not acquiring, 1 = owes a header, 2 = inside a frame
    int          m_phase, m_left, m_frames, m_ovf;
    int          m_pend, m_act;
    logic        e_wr, e_hdr, e_busy;
    logic [15:0] e_a, e_b;
    logic [15:0] src [4];
    int          sel_a [4] = '{0, 0, 1, 2};
    int          sel_b [4] = '{1, 2, 3, 3};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_left = 0; m_frames = 0; m_ovf = 0;
            m_pend = 0; m_act = 0;
            e_wr = 0; e_hdr = 0; e_busy = 0; e_a = 0; e_b = 0;
        end else begin
            e_wr  = 0;
            e_hdr = 0;
            src[0] = adc_a; src[1] = adc_b; src[2] = conv_a; src[3] = conv_b;
            if (m_phase == 0) begin
                if (start) m_phase = 1;
            end else if (m_phase == 1) begin
                if (!full_a && !full_b) begin
                    e_wr   = 1;
                    e_hdr  = 1;
                    e_a    = 16'(40960 + m_pend * 1024 + (m_frames % 1024));
                    e_b    = e_a;
                    m_act  = m_pend;
                    m_left = FRAME_LEN;
                    m_phase = 2;
                end
            end else if (smp_stb) begin
                if (full_a || full_b) begin
                    if (m_ovf < 255) m_ovf++;
                end else begin
                    e_wr = 1;
                    e_a  = src[sel_a[m_act]];
                    e_b  = src[sel_b[m_act]];
                    m_left--;
                    if (m_left == 0) begin
                        m_frames++;
                        m_phase = start ? 1 : 0;
                    end
                end
            end
            if (cfg_valid) m_pend = int'(cfg_mode);
            e_busy = (m_phase != 0);
        end
    end

    // ---------------- compare + capture ----------------
    logic [15:0] log_a[$], log_b[$], hdr_log[$];
    int          frame_samples[$];
    int          samples_since = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("wr_a", 32'(fifo_if.fifo_wr_a), 32'(e_wr));
            check("wr_b", 32'(fifo_if.fifo_wr_b), 32'(e_wr));
            if (e_wr) begin
                check("din_a", 32'(fifo_if.fifo_din_a), 32'(e_a));
                check("din_b", 32'(fifo_if.fifo_din_b), 32'(e_b));
            end
            check("frame_cnt", 32'(frame_cnt), 32'(16'(m_frames)));
            check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
            check("busy", 32'(busy), 32'(e_busy));
            if (fifo_if.fifo_wr_a) begin
                log_a.push_back(fifo_if.fifo_din_a);
                log_b.push_back(fifo_if.fifo_din_b);
                $display("WR %s a=%h b=%h t=%0t", e_hdr ? "HDR" : "SMP",
                         fifo_if.fifo_din_a, fifo_if.fifo_din_b, $time);
                if (e_hdr) begin
                    hdr_log.push_back(fifo_if.fifo_din_a);
                    frame_samples.push_back(samples_since);
                    samples_since = 0;
                end else begin
                    samples_since++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_strobes(input int count, input int full_lo, input int full_hi,
                               input int cfg_at, input logic [1:0] cfg_m, input int stop_at);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            adc_a  = 16'(i);
            adc_b  = 16'(4096 + i);
            conv_a = 16'(8192 + i);
            conv_b = 16'(12288 + i);
            full_b = (i >= full_lo && i <= full_hi);
            smp_stb = 1'b1;
            if (i == cfg_at) begin
                cfg_valid = 1'b1;
                cfg_mode  = cfg_m;
            end
            if (i == stop_at) start = 1'b0;
            @(negedge clk);
            smp_stb   = 1'b0;
            cfg_valid = 1'b0;
            full_b    = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wr", 32'(fifo_if.fifo_wr_a | fifo_if.fifo_wr_b), 32'd0);
        check("rst_din", 32'(fifo_if.fifo_din_a | fifo_if.fifo_din_b), 32'd0);
        check("rst_frame", 32'(frame_cnt), 32'd0);
        check("rst_ovf", 32'(ovf_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cfg_valid = 1'b1; cfg_mode = 2'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);

        // frame 0: mode 0, full_b for three strobes -> 258 strobes needed
        run_strobes(258, 150, 152, -1, 2'd0, -1);
        check("f0_ovf", 32'(ovf_cnt), 32'd3);
        check("f0_frames", 32'(frame_cnt), 32'd1);
        // frame 1: mode 0, new mode 3 arrives mid-frame
        run_strobes(255, 1000, -1, 50, 2'd3, -1);
        // frame 2: mode 3, start dropped after 100 samples
        run_strobes(255, 1000, -1, -1, 2'd0, 100);
        repeat (20) @(negedge clk);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_frames", 32'(frame_cnt), 32'd3);
        check("stop_hdrs", 32'(hdr_log.size()), 32'd3);

        // ARM blocked by full_a; strobes in ARM must be ignored
        full_a = 1'b1;
        start  = 1'b1;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            smp_stb = 1'b1;
            @(negedge clk);
            smp_stb = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("arm_ovf", 32'(ovf_cnt), 32'd3);
        check("arm_nohdr", 32'(hdr_log.size()), 32'd3);
        check("arm_busy", 32'(busy), 32'd1);
        full_a = 1'b0;
        @(negedge clk);
        check("arm_hdr_wr", 32'(fifo_if.fifo_wr_a), 32'd1);
        check("arm_hdr_val", 32'(fifo_if.fifo_din_a), 32'h0000AC03);
        repeat (2) @(negedge clk);
        run_strobes(10, 1000, -1, -1, 2'd0, -1);

        // asynchronous reset mid-frame
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_wr", 32'(fifo_if.fifo_wr_a | fifo_if.fifo_wr_b), 32'd0);
        check("arst_din", 32'(fifo_if.fifo_din_a | fifo_if.fifo_din_b), 32'd0);
        check("arst_frame", 32'(frame_cnt), 32'd0);
        check("arst_ovf", 32'(ovf_cnt), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_strobes(5, 1000, -1, -1, 2'd0, -1);

        // literal pins on captured words
        check("hdr_count", 32'(hdr_log.size()), 32'd5);
        if (hdr_log.size() == 5) begin
            check("hdr0", 32'(hdr_log[0]), 32'h0000A000);
            check("hdr1", 32'(hdr_log[1]), 32'h0000A001);
            check("hdr2", 32'(hdr_log[2]), 32'h0000AC02);
            check("hdr3", 32'(hdr_log[3]), 32'h0000AC03);
            check("hdr4", 32'(hdr_log[4]), 32'h0000A000);
            check("len0", 32'(frame_samples[1]), 32'd255);
            check("len1", 32'(frame_samples[2]), 32'd255);
            check("len2", 32'(frame_samples[3]), 32'd255);
        end
        check("log_size", 32'(log_a.size() >= 514), 32'd1);
        if (log_a.size() >= 514) begin
            check("f0_first_a", 32'(log_a[1]), 32'h00000000);
            check("f0_first_b", 32'(log_b[1]), 32'h00001000);
            check("f0_gap_a", 32'(log_a[151]), 32'h00000099);
            check("f0_gap_b", 32'(log_b[151]), 32'h00001099);
            check("f2_hdr", 32'(log_a[512]), 32'h0000AC02);
            check("f2_first_a", 32'(log_a[513]), 32'h00002000);
            check("f2_first_b", 32'(log_b[513]), 32'h00003000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_stream_ctrl.md
# acq_stream_ctrl

Frame scheduler between the two ADC/convolution sources and the two Ethernet FIFOs. When the Ethernet `start` command is active, it writes one tagged header word to both FIFOs, then streams the mode-selected sample pair on every ADC sample strobe until the frame is complete. It keeps the two channels word-aligned, drops sample pairs while either FIFO is full, and counts frames and overflows for the status block. It sits in the `clk_12` domain, replacing the free-running `start & cs_st` write enables.

## Interface
Parameters:
- `FRAME_LEN`, 255: sample pairs per frame, excluding the header. Header plus 255 samples gives 256 words, which matches the FIFO `rd_data_count[8]` threshold.
- `DATA_W`, 16: sample and FIFO word width.

Ports:
- `clk`  in  1  system clock (`clk_12`, 12.5 MHz). One clock; no other clock enters the block.
- `rst`  in  1  reset, asynchronous, active-high (`~locked_2`).
- `start`  in  1  level; Ethernet acquisition enable.
- `cfg_valid`  in  1  one-cycle pulse; new configuration from the parsed header.
- `cfg_mode`  in  2  source select, sampled when `cfg_valid`=1.
- `smp_stb`  in  1  one-cycle strobe per new ADC sample (CS rising edge).
- `adc_a`, `adc_b`  in  DATA_W each  ADC1 and ADC2 samples.
- `conv_a`, `conv_b`  in  DATA_W each  convolution outputs A and B.
- `fifo_full_a`, `fifo_full_b`  in  1 each  FIFO full flags, write side.
- `fifo_din_a`, `fifo_din_b`  out  DATA_W each  FIFO write data.
- `fifo_wr_a`, `fifo_wr_b`  out  1 each  FIFO write enables. Always asserted together.
- `frame_cnt`  out  16  count of completed frames, wraps.
- `ovf_cnt`  out  8  count of dropped sample pairs, saturating.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
Configuration:
- `mode_pend` is loaded from `cfg_mode` on every `cfg_valid`.
- `mode_act` is loaded from `mode_pend` only in the header-write cycle. Mode therefore never changes mid-frame.

Source mux, by `mode_act` (channel A / channel B):
- 0: `adc_a` / `adc_b`
- 1: `adc_a` / `conv_a`
- 2: `adc_b` / `conv_b`
- 3: `conv_a` / `conv_b`

State machine:
- IDLE: outputs quiet. Go to ARM when `start`=1.
- ARM:
  - If both full flags are 0: write header `{4'hA, mode_pend[1:0], frame_cnt[9:0]}` to both FIFOs, load `mode_act`, clear `smp_cnt`, go to STREAM.
  - Otherwise stay in ARM.
  - A `smp_stb` arriving in ARM is ignored; it is not counted as an overflow.
- STREAM, on `smp_stb`:
  - Both full flags 0: write the muxed pair and increment `smp_cnt`.
  - Either full flag 1: write nothing on either channel and increment `ovf_cnt` (saturates at 255). `smp_cnt` does not advance.
- Frame end: when the write making `smp_cnt`=FRAME_LEN occurs, `frame_cnt` increments. The next state is ARM if `start`=1, otherwise IDLE.
- `start` falling mid-frame: the frame completes; it is never truncated.
- `smp_cnt` width is clog2(FRAME_LEN+1).

## Timing
- Reset values: all outputs 0 and state IDLE; `mode_pend` and `mode_act` also reset to 0. The async assert takes effect immediately; a reset mid-frame abandons the frame without a trailing write.
- All outputs are registered. A sample write appears on `fifo_wr_*`/`fifo_din_*` one cycle after `smp_stb`, with the data sampled in the `smp_stb` cycle.
- Header: written one cycle after entering ARM if not full. Earliest header write is 2 cycles after `start` rises from IDLE.
- Full flags are sampled in the decision cycle. A FIFO that becomes full in the same cycle as the write is handled by the FIFO's own protection.
- `cfg_valid` in the header-write cycle: the header and `mode_act` use the old `mode_pend`; the new mode applies to the next frame.
- Back-to-back frames: ARM follows the last sample write with no idle cycle, so the header is written one cycle after the last sample.
- `frame_cnt` 0xFFFF wraps to 0. `ovf_cnt` holds at 0xFF.

## Structure
- Package `acq_pkg`:
  - state enum: IDLE, ARM, STREAM
  - mode encodings: MODE_ADC_ADC, MODE_ADC1_CONVA, MODE_ADC2_CONVB, MODE_CONV_CONV
  - `HDR_TAG` = 4'hA
- Sub-module `acq_src_mux`: a combinational 4-way pair select on `mode_act`.
- The FSM and counters live in the top of the block.

## Test plan
- Mode 0, `start`=1, 255 strobes every 8 cycles with `adc_a`=n, `adc_b`=0x1000+n → header 0xA000 on both channels, 255 pair writes, `frame_cnt`=1, second header 0xA001.
- Mode 3 pending, `cfg_valid` mid-frame with `cfg_mode`=3 → current frame keeps the mode-0 data; next header 0xAC01 and `conv_*` data follow.
- `fifo_full_b`=1 for 3 strobes mid-frame → no write on either channel, `ovf_cnt`=3, frame still contains exactly 255 samples.
- `start` dropped after 100 samples → 155 more samples written, then IDLE with `busy`=0 and no new header.
- `fifo_full_a`=1 while in ARM → no header and no `ovf_cnt` change; header written the cycle after the flag clears.
- `rst` pulsed mid-frame → all outputs 0 immediately; after release with `start`=1, header 0xA000 is written.
